// File: rtl/apbs_regmem.sv
// rtl/apbs_regmem.sv - APB slave word memory with programmable wait states and byte strobes
// Word 0 is a read-only ID; all outputs are registered.
module apbs_regmem #(
    parameter int          DEPTH       = 48,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [7:0]  PADDR,
    input  logic [31:0] PWDATA,
    input  logic [3:0]  PSTRB,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_READY = 2'd2;
    localparam logic [1:0] WAIT_INIT = 2'(WAIT_CYCLES);
    localparam logic [6:0] DEPTH_W   = 7'(DEPTH);
    localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [1:0]  r_state;
    logic [1:0]  r_cnt;
    logic        r_write;
    logic        r_err;
    logic [5:0]  r_idx;
    logic [31:0] r_wdata;
    logic [3:0]  r_strb;
    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_prdata;
    logic        r_pready;
    logic        r_pslverr;

    logic [5:0]  w_in_idx;
    logic        w_in_err;
    logic        w_setup;
    logic        w_access;
    logic [5:0]  w_rd_idx;
    logic        w_rd_err;
    logic        w_rd_write;
    logic        w_enter_ready;
    logic [31:0] w_rd_word;
    logic        w_commit;

    assign w_in_idx = PADDR[7:2];
    assign w_in_err = (PADDR[1:0] != 2'b00) || ({1'b0, w_in_idx} >= DEPTH_W)
                    || (PWRITE && (w_in_idx == 6'd0));
    assign w_setup  = (r_state == S_IDLE) && PSEL && !PENABLE;
    assign w_access = PSEL && PENABLE;

    // With zero wait states READY is entered straight from the setup edge,
    // so the read word must come from the live bus rather than the latches.
    assign w_rd_idx      = w_setup ? w_in_idx : r_idx;
    assign w_rd_err      = w_setup ? w_in_err : r_err;
    assign w_rd_write    = w_setup ? PWRITE   : r_write;
    assign w_enter_ready = (w_setup && (WAIT_CYCLES == 0))
                         || ((r_state == S_WAIT) && w_access && (r_cnt == 2'd1));
    assign w_rd_word     = w_rd_err ? 32'h0
                         : (w_rd_idx == 6'd0) ? ID_VALUE : r_mem[w_rd_idx[AW-1:0]];
    assign w_commit      = (r_state == S_READY) && w_access && r_write && !r_err;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state   <= S_IDLE;
            r_cnt     <= 2'd0;
            r_write   <= 1'b0;
            r_err     <= 1'b0;
            r_idx     <= 6'd0;
            r_wdata   <= 32'h0;
            r_strb    <= 4'h0;
            r_prdata  <= 32'h0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
        end else begin
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            if (w_enter_ready) begin
                r_pready  <= 1'b1;
                r_pslverr <= w_rd_err;
                if (!w_rd_write) begin
                    r_prdata <= w_rd_word;
                end
            end
            case (r_state)
                S_IDLE: begin
                    if (w_setup) begin
                        r_write <= PWRITE;
                        r_err   <= w_in_err;
                        r_idx   <= w_in_idx;
                        r_wdata <= PWDATA;
                        r_strb  <= PSTRB;
                        r_cnt   <= WAIT_INIT;
                        r_state <= (WAIT_CYCLES == 0) ? S_READY : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!PSEL) begin
                        r_state <= S_IDLE;
                        r_cnt   <= 2'd0;
                    end else if (PENABLE) begin
                        r_cnt <= r_cnt - 2'd1;
                        if (r_cnt == 2'd1) begin
                            r_state <= S_READY;
                        end
                    end
                end
                S_READY: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 32'h0;
            end
        end else if (w_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (r_strb[b]) begin
                    r_mem[r_idx[AW-1:0]][8*b +: 8] <= r_wdata[8*b +: 8];
                end
            end
        end
    end

    assign PRDATA  = r_prdata;
    assign PREADY  = r_pready;
    assign PSLVERR = r_pslverr;
endmodule

// File: doc/apbs_regmem.md
APBS_REGMEM -- requirements
Module: apbs_regmem

Interface
REQ-001 Parameter DEPTH, default 48, number of 32-bit words; legal range 2..64.
REQ-002 Parameter WAIT_CYCLES, default 1, wait states inserted per access; legal range 0..3.
REQ-003 Parameter ID_VALUE, default 32'hA5B0_0001, read-only content of word 0.
REQ-004 PCLK  in  1  sole clock; all state updates on its rising edge.
REQ-005 PRESET  in  1  reset, synchronous, active-high.
REQ-006 PSEL  in  1  slave select from the APB master.
REQ-007 PENABLE  in  1  access-phase indicator.
REQ-008 PWRITE  in  1  1 = write, 0 = read.
REQ-009 PADDR  in  8  byte address.
REQ-010 PWDATA  in  32  write data.
REQ-011 PSTRB  in  4  byte-lane write strobes; bit n enables PWDATA[8n+7:8n].
REQ-012 PRDATA  out  32  read data; registered.
REQ-013 PREADY  out  1  transfer completion; registered.
REQ-014 PSLVERR  out  1  transfer error, meaningful only while PREADY=1; registered.

Function
REQ-015 The word index shall be PADDR[7:2].
REQ-016 An access shall be erroneous if any of these holds: PADDR[1:0]!=0, index>=DEPTH, or a write to index 0.
REQ-017 The FSM shall have three states: IDLE, WAIT and READY.
REQ-018 In IDLE, a sampled setup phase (PSEL=1, PENABLE=0) shall latch PWRITE, PADDR, PWDATA, PSTRB and the error flag.
REQ-019 On that setup edge, a down-counter shall load WAIT_CYCLES.
REQ-020 On that setup edge, the FSM shall go to READY if WAIT_CYCLES=0, else to WAIT.
REQ-021 In WAIT, each edge with PSEL=1 and PENABLE=1 shall decrement the counter; at the edge where the counter equals 1, the FSM shall go to READY.
REQ-022 Latency: PREADY shall first be 1 in access cycle WAIT_CYCLES+1, counting the first cycle with PENABLE=1 as cycle 1.
REQ-023 PREADY shall be 1 only in READY, and READY shall last exactly one cycle before returning to IDLE.
REQ-024 When PREADY=1 for a read, PRDATA shall be the word at the index, or ID_VALUE for index 0.
REQ-025 When PREADY=1 for a read, PRDATA shall be 32'h0 if the access is erroneous.
REQ-026 When PREADY=1, PSLVERR shall equal the latched error flag; PSLVERR shall be 0 whenever PREADY=0.
REQ-027 A write shall commit at the edge sampling PREADY=1 with PSEL=1 and PENABLE=1, updating only the lanes whose PSTRB bit is 1.
REQ-028 An erroneous write shall modify nothing.
REQ-029 A write with PSTRB=4'b0000 shall complete without error and modify nothing.
REQ-030 PRDATA shall hold its last value outside READY.
REQ-031 Abort: PSEL=0 sampled in WAIT or READY shall return the FSM to IDLE with no write and PREADY=0 next cycle.
REQ-032 Protocol violation: PENABLE=1 sampled in IDLE shall be ignored, with no state change.
REQ-033 Back-to-back: a setup phase sampled on the cycle immediately after READY shall start a new transfer with the same latency.
REQ-034 Address wrap: the 8-bit PADDR cannot wrap; indices DEPTH..63 shall be reported as errors.

Reset
REQ-035 While PRESET=1 at an edge, the FSM shall go to IDLE and the counter shall clear.
REQ-036 While PRESET=1 at an edge, PREADY=0, PSLVERR=0 and PRDATA=32'h0.
REQ-037 While PRESET=1 at an edge, all memory words shall be set to 32'h0.
REQ-038 Reset asserted mid-transfer shall discard the transfer with no write; the next transfer after deassertion shall behave as after power-up.

Verification
REQ-039 WAIT_CYCLES=1: write 32'hDEAD_BEEF to 0x04 with PSTRB=4'hF, then read 0x04 -> PREADY high in access cycle 2, PRDATA=32'hDEAD_BEEF, PSLVERR=0.
REQ-040 Partial write: write 32'h1122_3344 with PSTRB=4'b0101 to 0x08 (previously 0), then read 0x08 -> 32'h0022_0044.
REQ-041 Error cases -> PSLVERR=1 with PREADY for each, and a read of 0x00 afterwards returns ID_VALUE:
        - read of 0xC0 (DEPTH=48): PRDATA=0;
        - write of 0x06 (misaligned);
        - write of 32'h0 to 0x00.
REQ-042 WAIT_CYCLES=0 and 3 builds: back-to-back reads -> PREADY high in access cycle 1 and access cycle 4 respectively, with no idle cycle required between transfers.
REQ-043 Abort, then reset:
        - drop PSEL during WAIT of a write to 0x10 -> 0x10 unchanged;
        - assert PRESET during a write in WAIT -> all outputs 0 next cycle, and a read of 0x10 returns 32'h0.
